// File: rtl/counter_rr_arbiter.sv
// Round-robin arbiter that shares one two-bit counter among four requesters.
// Optional hold-limit preemption is compiled in with `define ARB_HOLD_LIMIT_EN.
module counter_rr_arbiter #(
  parameter int NREQ = 4
`ifdef ARB_HOLD_LIMIT_EN
  ,
  parameter int HOLD_MAX = 4
`endif
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [NREQ-1:0] Req,
  output logic [NREQ-1:0] Gnt,
  output logic [1:0]      select,
  output logic            En,
  output logic            Busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [1:0]      sel_q, sel_d;
  logic            en_q, en_d;
  logic            busy_q, busy_d;
  logic [1:0]      winner_s;
  logic            preempt_s;

`ifdef ARB_HOLD_LIMIT_EN
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);
  logic [3:0]      hold_q, hold_d;
  logic [NREQ-1:0] others_s;
`endif

  function automatic logic [3:0] onehot2(input logic [1:0] idx);
    logic [3:0] v;
    case (idx)
      2'd0:    v = 4'b0001;
      2'd1:    v = 4'b0010;
      2'd2:    v = 4'b0100;
      2'd3:    v = 4'b1000;
      default: v = 4'b0000;
    endcase
    return v;
  endfunction

  // Rotate so the pointer lands on bit 0, take the lowest set bit, rotate back.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [3:0] rot;
    logic [1:0] off;
    rot = 4'({req, req} >> ptr);
    casez (rot)
      4'b???1: off = 2'd0;
      4'b??10: off = 2'd1;
      4'b?100: off = 2'd2;
      4'b1000: off = 2'd3;
      default: off = 2'd0;
    endcase
    return ptr + off;
  endfunction

  // Arbitration result for the current request vector and pointer.
  always_comb begin
    winner_s = rr_pick(Req, ptr_q);
  end

  // Next-state and next-output logic for the grant sequencer.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    en_d      = en_q;
    busy_d    = busy_q;
    preempt_s = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
    hold_d    = hold_q;
    others_s  = Req & ~gnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (Req != 4'b0000) begin
          state_d = GRANT;
          gnt_d   = onehot2(winner_s);
          sel_d   = winner_s;
          en_d    = 1'b1;
          busy_d  = 1'b1;
`ifdef ARB_HOLD_LIMIT_EN
          hold_d  = 4'd0;
`endif
        end else begin
          gnt_d  = 4'b0000;
          en_d   = 1'b0;
          busy_d = 1'b0;
        end
      end
      GRANT: begin
        en_d   = 1'b1;
        busy_d = 1'b1;
`ifdef ARB_HOLD_LIMIT_EN
        hold_d    = (hold_q == HOLD_LAST) ? hold_q : hold_q + 4'd1;
        preempt_s = (hold_q == HOLD_LAST) && (others_s != 4'b0000);
`endif
        if (!Req[sel_q] || preempt_s) begin
          state_d = RELEASE;
          gnt_d   = 4'b0000;
          en_d    = 1'b0;
          ptr_d   = sel_q + 2'd1;
        end else begin
          gnt_d = gnt_q;
        end
      end
      RELEASE: begin
        // Requests are deliberately ignored here; the next IDLE cycle arbitrates.
        state_d = IDLE;
        gnt_d   = 4'b0000;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
      hold_q  <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
`ifdef ARB_HOLD_LIMIT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  assign Gnt    = gnt_q;
  assign select = sel_q;
  assign En     = en_q;
  assign Busy   = busy_q;

endmodule
